// File: rtl/gpu_pkg.sv
// Shared GPU front-end constants: default geometry, instruction-memory FSM encoding
// and the boot program opcodes.
package gpu_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned BOOT_LEN   = 6;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } im_state_t;

  localparam logic [15:0] OP_LDI  = 16'h7132;
  localparam logic [15:0] OP_ADD  = 16'h1101;
  localparam logic [15:0] OP_SUB  = 16'h2202;
  localparam logic [15:0] OP_NOP  = 16'h0000;
  localparam logic [15:0] OP_JMP  = 16'h8400;
  localparam logic [15:0] OP_HALT = 16'hF000;

  // Boot program, indexed by word address.
  function automatic logic [15:0] boot_word(input logic [2:0] idx);
    logic [15:0] w;
    w = OP_NOP;
    case (idx)
      3'd0:    w = OP_LDI;
      3'd1:    w = OP_ADD;
      3'd2:    w = OP_SUB;
      3'd3:    w = OP_NOP;
      3'd4:    w = OP_JMP;
      3'd5:    w = OP_HALT;
      default: w = OP_NOP;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_boot_table.sv
// Combinational boot-program lookup: table word below BOOT_LEN, zero elsewhere.
module instr_boot_table #(
  parameter int unsigned DATA_W   = gpu_pkg::DATA_W_DEF,
  parameter int unsigned ADDR_W   = gpu_pkg::ADDR_W_DEF,
  parameter int unsigned BOOT_LEN = gpu_pkg::BOOT_LEN
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] word_c
);
  import gpu_pkg::*;

  always_comb begin
    word_c = '0;
    if (32'(addr) < BOOT_LEN) begin
      word_c = DATA_W'(boot_word(3'(addr)));
    end
  end

endmodule

// File: rtl/instr_mem.sv
// Instruction memory with boot loader FSM, synchronous read-first fetch port and host
// write port. Define INSTR_MEM_PARITY_EN to store and check one even-parity bit per word.
module instr_mem #(
  parameter int unsigned DATA_W   = gpu_pkg::DATA_W_DEF,
  parameter int unsigned ADDR_W   = gpu_pkg::ADDR_W_DEF,
  parameter int unsigned BOOT_LEN = gpu_pkg::BOOT_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  output logic              busy,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              inj_perr,
  output logic              rd_perr
);
  import gpu_pkg::*;

  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef INSTR_MEM_PARITY_EN
  localparam int unsigned MEM_W = DATA_W + 1;
`else
  localparam int unsigned MEM_W = DATA_W;
`endif

  im_state_t         state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] boot_c;
  logic              host_we_c;
  logic              we_c;
  logic [ADDR_W-1:0] waddr_c;
  logic [DATA_W-1:0] wdata_c;
  logic [MEM_W-1:0]  wword_c;
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  mem [DEPTH];

  instr_boot_table #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .BOOT_LEN (BOOT_LEN)
  ) u_boot (
    .addr   (cnt),
    .word_c (boot_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      cnt      <= '0;
      busy     <= 1'b1;
      wr_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      busy     <= (state_nxt == ST_INIT);
      wr_ready <= (state_nxt == ST_READY);
    end
  end

  // INIT walks every entry once; init_req restarts the walk only from READY.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_INIT: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == '1) begin
          state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (init_req) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Single write port shared by the boot walk and the host; they never overlap.
  always_comb begin
    host_we_c = wr_valid & wr_ready;
    we_c      = (state == ST_INIT) | host_we_c;
    waddr_c   = (state == ST_INIT) ? cnt : wr_addr;
    wdata_c   = (state == ST_INIT) ? boot_c : wr_data;
  end

`ifdef INSTR_MEM_PARITY_EN
  assign wword_c = {(^wdata_c) ^ (host_we_c & inj_perr), wdata_c};
  assign rd_perr = rd_valid & (^rd_word);
`else
  logic unused_inj_perr;
  assign unused_inj_perr = inj_perr;
  assign wword_c = wdata_c;
  assign rd_perr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[waddr_c] <= wword_c;
    end
  end

  // Read-first: the read register samples the array before a same-edge write lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_word  <= '0;
    end else begin
      rd_valid <= rd_en & (state == ST_READY);
      if (rd_en && (state == ST_READY)) begin
        rd_word <= mem[rd_addr];
      end
    end
  end

  assign rd_data = rd_word[DATA_W-1:0];

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem: boot timing, fetches, read-first writes, re-init and
// mid-INIT reset, parity hook; expected fetch results flow through a scoreboard queue.
module tb_instr_mem;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
`ifdef INSTR_MEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic          init_req = 1'b0;
  logic          busy;
  logic          rd_en    = 1'b0;
  logic [AW-1:0] rd_addr  = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr  = '0;
  logic [DW-1:0] wr_data  = '0;
  logic          inj_perr = 1'b0;
  logic          rd_perr;

  int checks   = 0;
  int failures = 0;
  logic [DW:0] exp_q [$];

  instr_mem dut (
    .clk      (clk),
    .rst      (rst),
    .init_req (init_req),
    .busy     (busy),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .inj_perr (inj_perr),
    .rd_perr  (rd_perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts consecutive busy cycles from now; wr_ready must stay low throughout.
  task automatic count_busy(input string tag, input int exp_len);
    int n;
    bit wr_seen;
    n = 0;
    wr_seen = 1'b0;
    while (busy === 1'b1 && n < 1000) begin
      if (wr_ready !== 1'b0) wr_seen = 1'b1;
      n++;
      @(posedge clk);
      #1;
    end
    chk({tag, "_len"}, 32'(n), 32'(exp_len));
    chk({tag, "_wr_ready_low"}, 32'(wr_seen), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_wr_ready_after"}, 32'(wr_ready), 32'd1);
  endtask

  // One clock of stimulus; a read pushes its expectation, popped once the DUT responds.
  task automatic step(input string tag, input bit rd, input logic [AW-1:0] ra,
                      input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit inj, input bit ini, input bit ev,
                      input logic [DW-1:0] ed, input bit ep);
    logic [DW:0] e;
    @(negedge clk);
    rd_en = rd; rd_addr = ra;
    wr_valid = wr; wr_addr = wa; wr_data = wd; inj_perr = inj;
    init_req = ini;
    if (wr) chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    if (ev) exp_q.push_back({ep, ed});
    @(posedge clk);
    #1;
    rd_en = 1'b0; wr_valid = 1'b0; inj_perr = 1'b0; init_req = 1'b0;
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(ev));
    if (ev) begin
      e = exp_q.pop_front();
      chk({tag, "_rd_data"}, 32'(rd_data), 32'(e[DW-1:0]));
      chk({tag, "_rd_perr"}, 32'(rd_perr), 32'(e[DW]));
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_perr", 32'(rd_perr), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    count_busy("boot", 256);

    step("rd0", 1'b1, 8'd0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h7132, 1'b0);
    step("hold", 1'b0, 8'd0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("hold_rd_data", 32'(rd_data), 32'h7132);
    step("rd5", 1'b1, 8'd5, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b1, 16'hF000, 1'b0);
    step("rd200", 1'b1, 8'd200, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    step("rd255", 1'b1, 8'd255, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);

    step("rw3", 1'b1, 8'd3, 1'b1, 8'd3, 16'hABCD, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    step("rd3_new", 1'b1, 8'd3, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b1, 16'hABCD, 1'b0);

    step("wr7_inj", 1'b0, 8'd0, 1'b1, 8'd7, 16'h00FF, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step("rd7_inj", 1'b1, 8'd7, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h00FF, PAR);
    step("wr7", 1'b0, 8'd0, 1'b1, 8'd7, 16'h00FE, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step("rd7", 1'b1, 8'd7, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h00FE, 1'b0);

    step("wr10", 1'b0, 8'd0, 1'b1, 8'd10, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step("rd10", 1'b1, 8'd10, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
    step("wr20_init", 1'b0, 8'd0, 1'b1, 8'd20, 16'h5555, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    count_busy("reinit", 256);
    step("rd10_after", 1'b1, 8'd10, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    step("rd20_after", 1'b1, 8'd20, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
    step("rd0_after", 1'b1, 8'd0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h7132, 1'b0);

    // A second init_req one cycle into INIT must not restart the walk.
    step("init3", 1'b0, 8'd0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    step("init3_again", 1'b0, 8'd0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    count_busy("init_ignored", 255);

    step("init4", 1'b0, 8'd0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    step("rd_in_init", 1'b1, 8'd0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    repeat (99) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    chk("midrst_wr_ready", 32'(wr_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    count_busy("restart", 256);
    step("rd0_restart", 1'b1, 8'd0, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h7132, 1'b0);
    step("rd3_restart", 1'b1, 8'd3, 1'b0, 8'd0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem.md
INSTR_MEM -- requirements
Module: instr_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 16, instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter BOOT_LEN, default 6, number of boot-program words.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port init_req  input  1  pulse: reload boot program.
REQ-007 SHALL have port busy  output  1  high while boot loading.
REQ-008 SHALL have port rd_en  input  1  fetch request.
REQ-009 SHALL have port rd_addr  input  ADDR_W  fetch address.
REQ-010 SHALL have port rd_valid  output  1  rd_data valid strobe.
REQ-011 SHALL have port rd_data  output  DATA_W  fetched word.
REQ-012 SHALL have port wr_valid  input  1  host write request.
REQ-013 SHALL have port wr_ready  output  1  write accepted when high with wr_valid.
REQ-014 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-015 SHALL have port wr_data  input  DATA_W  write word.
REQ-016 SHALL have port inj_perr  input  1  on accepted write, store inverted parity (test hook).
REQ-017 SHALL have port rd_perr  output  1  parity error on current rd_data.

Function
REQ-018 SHALL implement FSM with states INIT and READY.
REQ-019 SHALL, in INIT, write boot word for address k into entry k on cycle k, for k = 0..DEPTH-1, then go to READY; INIT lasts exactly DEPTH cycles.
REQ-020 SHALL use boot words: entries 0..BOOT_LEN-1 from boot table, all others 0x0000.
REQ-021 SHALL drive busy=1 in INIT and busy=0 in READY.
REQ-022 SHALL, in READY, return mem[rd_addr] on rd_data with rd_valid=1 exactly one cycle after a cycle with rd_en=1.
REQ-023 SHALL hold rd_data and drive rd_valid=0 in the cycle after rd_en=0.
REQ-024 SHALL ignore rd_en in INIT (rd_valid=0 next cycle).
REQ-025 SHALL drive wr_ready=1 only in READY; write occurs on wr_valid and wr_ready.
REQ-026 SHALL, on simultaneous read and write to same address, return old contents (read-first); new value visible from the next read.
REQ-027 SHALL, on init_req in READY, enter INIT next cycle with counter 0; init_req during INIT is ignored.
REQ-028 SHALL, on an accepted write coinciding with init_req, perform the write before INIT begins; INIT then overwrites it.
REQ-029 SHALL wrap address counters modulo DEPTH; no out-of-range case exists.

Reset
REQ-030 SHALL on rst: state=INIT, counter=0, busy=1, rd_valid=0, rd_data=0, wr_ready=0, rd_perr=0.
REQ-031 SHALL, on rst asserted mid-INIT or mid-read, abort and restart INIT after deassertion; memory contents undefined until INIT completes.

Configuration
REQ-032 SHALL, with INSTR_MEM_PARITY_EN defined, store one even-parity bit per word (generated on every write, INIT included, inverted when inj_perr) and assert rd_perr with rd_valid on mismatch.
REQ-033 SHALL, without INSTR_MEM_PARITY_EN, store no parity bit, ignore inj_perr and tie rd_perr to 0.

Structure
REQ-034 SHALL place DATA_W/ADDR_W defaults, BOOT_LEN, state encoding (INIT, READY) and boot opcode constants in shared package gpu_pkg.
REQ-035 SHALL implement boot words in a combinational sub-module instr_boot_table (addr in, word out; 0 beyond BOOT_LEN).
REQ-036 SHALL infer memory as synchronous-read block RAM.

Verification
REQ-037 SHALL check: release rst -> busy=1 for exactly 256 cycles, then busy=0, wr_ready=1.
REQ-038 SHALL check: after INIT, rd_en addr 0 -> next cycle rd_valid=1, rd_data=0x7132; addr 5 -> 0xF000; addr 200 -> 0x0000.
REQ-039 SHALL check: write 0xABCD to addr 3 with read of addr 3 same cycle -> rd_data=0x0000 (old); next read of addr 3 -> 0xABCD.
REQ-040 SHALL check: init_req after writing 0x1234 to addr 10 -> busy=1 for 256 cycles, wr_ready=0 throughout, then addr 10 reads 0x0000.
REQ-041 SHALL check: rst asserted at INIT cycle 100 -> busy stays 1, INIT restarts, full 256 cycles after release.
REQ-042 SHALL check (INSTR_MEM_PARITY_EN): write addr 7 with inj_perr=1 -> read addr 7 gives rd_perr=1; rewrite with inj_perr=0 -> rd_perr=0.
